// File: rtl/fifo_burst_drain.sv
// Drains BURST words from a synchronous FIFO via rd_en/rd_ack/rd_err and reports their sum.
// Optional WAIT timeout is enabled by defining FIFO_BURST_DRAIN_TIMEOUT_EN.
module fifo_burst_drain #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned BURST  = 4,
   parameter int unsigned SUM_W  = 36
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              empty,
   input  logic              rd_ack,
   input  logic              rd_err,
   input  logic [DATA_W-1:0] d_in,
   output logic              rd_en,
   output logic [SUM_W-1:0]  sum,
   output logic [3:0]        word_count,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam logic [3:0] BurstLen = 4'(BURST);

   typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

   state_e           state_q, state_d;
   logic             rd_en_q, rd_en_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic             busy_q, busy_d;
   logic [SUM_W-1:0] sum_q, sum_d;
   logic [3:0]       cnt_q, cnt_d;

`ifdef FIFO_BURST_DRAIN_TIMEOUT_EN
   // Reaching this value on a silent WAIT cycle means 15 cycles without a response.
   localparam logic [3:0] TmoLast = 4'd14;
   logic [3:0] tmo_q, tmo_d;
`endif

   always_comb begin
      state_d = state_q;
      rd_en_d = 1'b0;
      done_d  = 1'b0;
      err_d   = err_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
`ifdef FIFO_BURST_DRAIN_TIMEOUT_EN
      tmo_d   = tmo_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (start) begin
               sum_d   = '0;
               cnt_d   = '0;
               err_d   = 1'b0;
               state_d = StReq;
            end
         end
         StReq: begin
            if (!empty) begin
               rd_en_d = 1'b1;
               state_d = StWait;
`ifdef FIFO_BURST_DRAIN_TIMEOUT_EN
               tmo_d   = '0;
`endif
            end
         end
         StWait: begin
            // An error wins over a simultaneous ack; the word is retried.
            if (rd_err) begin
               err_d   = 1'b1;
               state_d = StReq;
            end else if (rd_ack) begin
               sum_d   = sum_q + SUM_W'(d_in);
               cnt_d   = cnt_q + 4'd1;
               done_d  = (cnt_d == BurstLen);
               state_d = (cnt_d == BurstLen) ? StDone : StReq;
`ifdef FIFO_BURST_DRAIN_TIMEOUT_EN
            end else if (tmo_q == TmoLast) begin
               err_d   = 1'b1;
               done_d  = 1'b1;
               state_d = StDone;
            end else begin
               tmo_d   = tmo_q + 4'd1;
`endif
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         rd_en_q <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         sum_q   <= '0;
         cnt_q   <= '0;
`ifdef FIFO_BURST_DRAIN_TIMEOUT_EN
         tmo_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         rd_en_q <= rd_en_d;
         done_q  <= done_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
`ifdef FIFO_BURST_DRAIN_TIMEOUT_EN
         tmo_q   <= tmo_d;
`endif
      end
   end

   assign rd_en      = rd_en_q;
   assign done       = done_q;
   assign err        = err_q;
   assign busy       = busy_q;
   assign sum        = sum_q;
   assign word_count = cnt_q;

endmodule

// File: tb/tb_fifo_burst_drain.sv
// Bench for fifo_burst_drain: queue-based FIFO model with error injection, table vectors,
// hand-written corner sequences and randomized bursts checked against a burst-sum model.
module tb_fifo_burst_drain;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        empty = 1'b1;
   logic        rd_ack = 1'b0;
   logic        rd_err = 1'b0;
   logic [31:0] d_in = '0;
   logic        rd_en, busy, done, err;
   logic [35:0] sum;
   logic [3:0]  word_count;

   fifo_burst_drain dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .empty      (empty),
      .rd_ack     (rd_ack),
      .rd_err     (rd_err),
      .d_in       (d_in),
      .rd_en      (rd_en),
      .sum        (sum),
      .word_count (word_count),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   // FIFO model. Injection codes per read: 0 normal, 1 rd_err, 2 rd_ack+rd_err, 3 no response.
   logic [31:0] fifo_q [$];
   int          inj_q [$];
   logic        push_v = 1'b0;
   logic        inj_v = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] push_w = '0;
   int          inj_w = 0;
   int          rd_on_empty = 0;

   always @(posedge clk) begin
      int code;
      rd_ack <= 1'b0;
      rd_err <= 1'b0;
      if (flush) begin
         fifo_q.delete();
         inj_q.delete();
      end else if (rd_en === 1'b1) begin
         code = 0;
         if (inj_q.size() > 0) code = inj_q.pop_front();
         if (code == 1) begin
            rd_err <= 1'b1;
         end else if (code == 2) begin
            rd_err <= 1'b1;
            rd_ack <= 1'b1;
            d_in   <= 32'hDEAD_BEEF;
         end else if (code == 0) begin
            if (fifo_q.size() == 0) begin
               rd_on_empty++;
               rd_err <= 1'b1;
            end else begin
               d_in   <= fifo_q.pop_front();
               rd_ack <= 1'b1;
            end
         end
      end
      if (push_v) fifo_q.push_back(push_w);
      if (inj_v) inj_q.push_back(inj_w);
      empty <= (fifo_q.size() == 0);
   end

   int   rd_tot = 0, done_tot = 0, rd_dbl = 0;
   logic prev_rd = 1'b0;

   always @(negedge clk) begin
      if (rd_en === 1'b1) begin
         rd_tot++;
         if (prev_rd) rd_dbl++;
      end
      prev_rd = (rd_en === 1'b1);
      if (done === 1'b1) done_tot++;
   end

   int n_checks = 0, n_pass = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
   endtask

   task automatic push_word(input logic [31:0] w);
      push_w = w;
      push_v = 1'b1;
      @(negedge clk);
      push_v = 1'b0;
   endtask

   task automatic inj_code(input int c);
      inj_w = c;
      inj_v = 1'b1;
      @(negedge clk);
      inj_v = 1'b0;
   endtask

   task automatic do_flush();
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n = 0;
      while (done !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_done_seen"}, 64'(done), 64'd1);
   endtask

   task automatic check_burst(input string tag, input logic [35:0] es, input int ewc,
                              input logic ee, input int erd, input int rd0, input int dn0);
      @(negedge clk);
      check({tag, "_sum"}, 64'(sum), 64'(es));
      check({tag, "_wc"}, 64'(word_count), 64'(ewc));
      check({tag, "_err"}, 64'(err), 64'(ee));
      check({tag, "_rd_en_pulses"}, 64'(rd_tot - rd0), 64'(erd));
      check({tag, "_done_pulses"}, 64'(done_tot - dn0), 64'd1);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_done_low"}, 64'(done), 64'd0);
   endtask

   typedef struct packed {
      logic [3:0][31:0] w;
      logic [3:0]       inj_at;
      logic [1:0]       inj_kind;
      logic [35:0]      exp_sum;
      logic             exp_err;
      logic [3:0]       exp_rd;
   } vec_t;

   function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                               input logic [31:0] d, input int at, input int kind,
                               input logic [35:0] s, input logic e, input int rd);
      vec_t v;
      v.w[0] = a; v.w[1] = b; v.w[2] = c; v.w[3] = d;
      v.inj_at   = 4'(at);
      v.inj_kind = 2'(kind);
      v.exp_sum  = s;
      v.exp_err  = e;
      v.exp_rd   = 4'(rd);
      return v;
   endfunction

   task automatic run_vec(input string tag, input vec_t v);
      int rd0, dn0;
      do_flush();
      if (v.inj_kind != 2'd0) begin
         for (int k = 0; k < int'(v.inj_at); k++) inj_code(0);
         inj_code(int'(v.inj_kind));
      end
      for (int k = 0; k < 4; k++) push_word(v.w[k]);
      @(negedge clk);
      rd0 = rd_tot;
      dn0 = done_tot;
      pulse_start();
      wait_done(tag, 100);
      check_burst(tag, v.exp_sum, 4, v.exp_err, int'(v.exp_rd), rd0, dn0);
   endtask

   // Reference: the burst sum is the first four words queued, err is set iff any read was
   // answered with an error, and each errored read costs one extra rd_en pulse.
   task automatic run_random(input int it);
      logic [31:0] rw [4];
      logic [35:0] es = '0;
      int nerr = 0, zeros = 0, n = 0, pushed, rd0, dn0, r;
      string tag;
      tag = $sformatf("rnd%0d", it);
      do_flush();
      while (zeros < 4) begin
         r = int'($urandom_range(0, 9));
         if (r < 6) begin
            inj_code(0);
            zeros++;
         end else begin
            inj_code((r < 8) ? 1 : 2);
            nerr++;
         end
      end
      for (int k = 0; k < 4; k++) begin
         rw[k] = $urandom;
         es    = es + 36'(rw[k]);
      end
      pushed = int'($urandom_range(0, 4));
      for (int k = 0; k < pushed; k++) push_word(rw[k]);
      @(negedge clk);
      rd0 = rd_tot;
      dn0 = done_tot;
      pulse_start();
      while (done !== 1'b1 && n < 300) begin
         push_v = (pushed < 4) && ($urandom_range(0, 2) == 0);
         if (push_v) begin
            push_w = rw[pushed];
            pushed++;
         end
         start = (busy === 1'b1) && ($urandom_range(0, 3) == 0);
         @(negedge clk);
         n++;
      end
      push_v = 1'b0;
      start  = 1'b0;
      check({tag, "_done_seen"}, 64'(done), 64'd1);
      check_burst(tag, es, 4, logic'(nerr != 0), 4 + nerr, rd0, dn0);
   endtask

   vec_t tbl [6];

   initial begin
      int rd0, dn0, n;
      tbl[0] = mk(32'd1, 32'd2, 32'd3, 32'd4, 0, 0, 36'd10, 1'b0, 4);
      tbl[1] = mk(32'd1, 32'd2, 32'd3, 32'd4, 1, 1, 36'd10, 1'b1, 5);
      tbl[2] = mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0,
                  36'h3_FFFF_FFFC, 1'b0, 4);
      tbl[3] = mk(32'h10, 32'h20, 32'h30, 32'h40, 0, 2, 36'hA0, 1'b1, 5);
      tbl[4] = mk(32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1, 3, 1,
                  36'h1_8000_0000, 1'b1, 5);
      tbl[5] = mk(32'd0, 32'd0, 32'd0, 32'd0, 0, 0, 36'd0, 1'b0, 4);

      repeat (3) @(negedge clk);
      check("reset_rd_en", 64'(rd_en), 64'd0);
      check("reset_done", 64'(done), 64'd0);
      check("reset_err", 64'(err), 64'd0);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_sum", 64'(sum), 64'd0);
      check("reset_wc", 64'(word_count), 64'd0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 6; i++) run_vec($sformatf("tbl%0d", i), tbl[i]);

      // Start with an empty FIFO: no reads until data arrives.
      do_flush();
      @(negedge clk);
      rd0 = rd_tot;
      dn0 = done_tot;
      pulse_start();
      repeat (10) @(negedge clk);
      check("empty_no_rd_en", 64'(rd_tot - rd0), 64'd0);
      check("empty_busy", 64'(busy), 64'd1);
      check("empty_no_done", 64'(done_tot - dn0), 64'd0);
      for (int k = 0; k < 4; k++) push_word(32'd5);
      wait_done("empty", 100);
      check_burst("empty", 36'h14, 4, 1'b0, 4, rd0, dn0);

      // Reset mid-burst after two accepted words, with err already set.
      do_flush();
      inj_code(1);
      for (int k = 1; k <= 4; k++) push_word(32'(k));
      @(negedge clk);
      pulse_start();
      n = 0;
      while (word_count !== 4'd2 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("rst_wc_two", 64'(word_count), 64'd2);
      check("rst_err_set", 64'(err), 64'd1);
      #1 reset_n = 1'b0;
      #1;
      check("rst_async_rd_en", 64'(rd_en), 64'd0);
      check("rst_async_done", 64'(done), 64'd0);
      check("rst_async_err", 64'(err), 64'd0);
      check("rst_async_busy", 64'(busy), 64'd0);
      check("rst_async_sum", 64'(sum), 64'd0);
      check("rst_async_wc", 64'(word_count), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      push_word(32'd7);
      push_word(32'd8);
      @(negedge clk);
      rd0 = rd_tot;
      dn0 = done_tot;
      pulse_start();
      wait_done("rst_resume", 100);
      check_burst("rst_resume", 36'd22, 4, 1'b0, 4, rd0, dn0);

`ifdef FIFO_BURST_DRAIN_TIMEOUT_EN
      // Second read never answered: timeout ends the burst with a partial result.
      do_flush();
      inj_code(0);
      inj_code(3);
      for (int k = 1; k <= 4; k++) push_word(32'(k));
      @(negedge clk);
      rd0 = rd_tot;
      dn0 = done_tot;
      pulse_start();
      wait_done("timeout", 100);
      check_burst("timeout", 36'd1, 1, 1'b1, 2, rd0, dn0);
`endif

      for (int it = 0; it < 20; it++) run_random(it);

      check("rd_en_single_cycle", 64'(rd_dbl), 64'd0);
      check("no_read_on_empty", 64'(rd_on_empty), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
